// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Fetch-stage lookup is combinational; training happens from the EX stage
// when a conditional branch resolves, together with misprediction recovery
// and resolved/mispredicted branch statistics.
module btb_predictor #(
   parameter int IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] PCF,
   output logic        PredictedF,
   output logic [31:0] PredictedPCF,
   input  logic        enE,
   input  logic        BranchE,
   input  logic        BrTakenE,
   input  logic [31:0] PCE,
   input  logic [31:0] BrTargetE,
   input  logic        PredictedE,
   output logic        MispredictE,
   output logic [31:0] RecoverPCE,
   output logic [31:0] BranchCnt,
   output logic [31:0] MispredCnt
);

   localparam int ENTRIES = 1 << IDX_W;
   localparam int TAG_W   = 30 - IDX_W;

   // Table storage: valid and counter are reset, tag and target are not.
   logic             r_valid  [ENTRIES];
   logic [TAG_W-1:0] r_tag    [ENTRIES];
   logic [31:0]      r_target [ENTRIES];
   logic [1:0]       r_ctr    [ENTRIES];

   logic [31:0] r_branch_cnt;
   logic [31:0] r_mispred_cnt;

   logic [IDX_W-1:0] w_f_idx;
   logic [TAG_W-1:0] w_f_tag;
   logic [IDX_W-1:0] w_e_idx;
   logic [TAG_W-1:0] w_e_tag;
   logic             w_f_hit;
   logic             w_e_hit;
   logic             w_update;
   logic             w_mispredict;

   // Two-bit saturating counter step: up on taken, down on not taken.
   function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
      end else begin
         res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
      end
      return res;
   endfunction

   // 32-bit statistics counter that sticks at all-ones.
   function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
      return (cnt == 32'hFFFF_FFFF) ? 32'hFFFF_FFFF : cnt + 32'd1;
   endfunction

   assign w_f_idx = PCF[IDX_W+1:2];
   assign w_f_tag = PCF[31:IDX_W+2];
   assign w_e_idx = PCE[IDX_W+1:2];
   assign w_e_tag = PCE[31:IDX_W+2];

   assign w_f_hit      = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
   assign w_e_hit      = r_valid[w_e_idx] && (r_tag[w_e_idx] == w_e_tag);
   assign w_update     = enE & BranchE;
   assign w_mispredict = BranchE & (PredictedE != BrTakenE);

   // Fetch lookup: predict taken only on a hit with a taken-leaning counter.
   always_comb begin
      PredictedF   = 1'b0;
      PredictedPCF = 32'd0;
      if (w_f_hit && r_ctr[w_f_idx][1]) begin
         PredictedF   = 1'b1;
         PredictedPCF = r_target[w_f_idx];
      end else begin
         PredictedF   = 1'b0;
         PredictedPCF = 32'd0;
      end
   end

   // Recovery path: redirect to the resolved target, or fall through.
   always_comb begin
      MispredictE = w_mispredict;
      if (BrTakenE) begin
         RecoverPCE = BrTargetE;
      end else begin
         RecoverPCE = PCE + 32'd4;
      end
   end

   // Table training and statistics; reset wins over a concurrent update.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            r_valid[i] <= 1'b0;
            r_ctr[i]   <= 2'b00;
         end
         r_branch_cnt  <= 32'd0;
         r_mispred_cnt <= 32'd0;
      end else if (w_update) begin
         if (w_e_hit) begin
            r_ctr[w_e_idx] <= ctr_next(r_ctr[w_e_idx], BrTakenE);
            if (BrTakenE) begin
               r_target[w_e_idx] <= BrTargetE;
            end
         end else if (BrTakenE) begin
            // Allocate on a taken miss, evicting whatever aliased here.
            r_valid[w_e_idx]  <= 1'b1;
            r_tag[w_e_idx]    <= w_e_tag;
            r_target[w_e_idx] <= BrTargetE;
            r_ctr[w_e_idx]    <= 2'b10;
         end
         r_branch_cnt <= sat_inc(r_branch_cnt);
         if (w_mispredict) begin
            r_mispred_cnt <= sat_inc(r_mispred_cnt);
         end
      end
   end

   assign BranchCnt  = r_branch_cnt;
   assign MispredCnt = r_mispred_cnt;

endmodule

// File: tb/tb_btb_predictor.sv
// Scoreboard bench for btb_predictor: stimulus pushes expected output values,
// a negedge monitor pops and compares them against the DUT.
module tb_btb_predictor;

   logic        clk;
   logic        rst;
   logic [31:0] PCF;
   logic        PredictedF;
   logic [31:0] PredictedPCF;
   logic        enE;
   logic        BranchE;
   logic        BrTakenE;
   logic [31:0] PCE;
   logic [31:0] BrTargetE;
   logic        PredictedE;
   logic        MispredictE;
   logic [31:0] RecoverPCE;
   logic [31:0] BranchCnt;
   logic [31:0] MispredCnt;

   typedef struct {
      int          id;
      logic [31:0] val;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 1'b0;

   localparam int ID_PF  = 0;
   localparam int ID_PPC = 1;
   localparam int ID_MP  = 2;
   localparam int ID_RPC = 3;
   localparam int ID_BC  = 4;
   localparam int ID_MC  = 5;

   btb_predictor #(.IDX_W(6)) dut (
      .clk(clk), .rst(rst), .PCF(PCF),
      .PredictedF(PredictedF), .PredictedPCF(PredictedPCF),
      .enE(enE), .BranchE(BranchE), .BrTakenE(BrTakenE),
      .PCE(PCE), .BrTargetE(BrTargetE), .PredictedE(PredictedE),
      .MispredictE(MispredictE), .RecoverPCE(RecoverPCE),
      .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] actual(input int id);
      case (id)
         ID_PF:   return {31'd0, PredictedF};
         ID_PPC:  return PredictedPCF;
         ID_MP:   return {31'd0, MispredictE};
         ID_RPC:  return RecoverPCE;
         ID_BC:   return BranchCnt;
         ID_MC:   return MispredCnt;
         default: return 32'hDEAD_BEEF;
      endcase
   endfunction

   function automatic string id_name(input int id);
      case (id)
         ID_PF:   return "PredictedF";
         ID_PPC:  return "PredictedPCF";
         ID_MP:   return "MispredictE";
         ID_RPC:  return "RecoverPCE";
         ID_BC:   return "BranchCnt";
         ID_MC:   return "MispredCnt";
         default: return "unknown";
      endcase
   endfunction

   // Monitor: outputs are settled mid-cycle, so drain the queue on negedge.
   always @(negedge clk) begin
      exp_t e;
      logic [31:0] a;
      while (q.size() > 0) begin
         e = q.pop_front();
         a = actual(e.id);
         checks++;
         if (a !== e.val) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", id_name(e.id), a, e.val, $time);
         end
      end
   end

   task automatic expv(input int id, input logic [31:0] v);
      exp_t e;
      e.id  = id;
      e.val = v;
      q.push_back(e);
   endtask

   task automatic exp_state(input logic pf, input logic [31:0] ppc,
                            input logic [31:0] bc, input logic [31:0] mc);
      expv(ID_PF, {31'd0, pf});
      expv(ID_PPC, ppc);
      expv(ID_BC, bc);
      expv(ID_MC, mc);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic br(input logic en, input logic b, input logic tk,
                     input logic [31:0] pce, input logic [31:0] tgt, input logic pe);
      enE        = en;
      BranchE    = b;
      BrTakenE   = tk;
      PCE        = pce;
      BrTargetE  = tgt;
      PredictedE = pe;
   endtask

   task automatic idle();
      br(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      PCF = 32'h0000_0100;
      idle();
      step();
      step();
      rst = 1'b0;

      // Reset state
      exp_state(1'b0, 32'd0, 32'd0, 32'd0);
      expv(ID_MP, 32'd0);
      step();

      // Taken miss allocates; lookup in the same cycle sees old contents
      br(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0);
      expv(ID_MP, 32'd1);
      expv(ID_RPC, 32'h80);
      expv(ID_PF, 32'd0);
      step();
      idle();
      exp_state(1'b1, 32'h80, 32'd1, 32'd1);
      expv(ID_MP, 32'd0);
      step();

      // Not-taken from ctr=10 -> 01, prediction drops
      br(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b1);
      expv(ID_MP, 32'd1);
      expv(ID_RPC, 32'h104);
      step();
      idle();
      exp_state(1'b0, 32'd0, 32'd2, 32'd2);
      step();

      // Two more not-taken: 01 -> 00 -> 00
      br(1'b1, 1'b1, 1'b0, 32'h100, 32'h80, 1'b0);
      expv(ID_MP, 32'd0);
      step();
      step();
      idle();
      exp_state(1'b0, 32'd0, 32'd4, 32'd2);
      step();

      // Taken from 00 -> 01 (still not predicted), then 01 -> 10 with new target
      br(1'b1, 1'b1, 1'b1, 32'h100, 32'h80, 1'b0);
      step();
      idle();
      exp_state(1'b0, 32'd0, 32'd5, 32'd3);
      step();
      br(1'b1, 1'b1, 1'b1, 32'h100, 32'h90, 1'b0);
      step();
      idle();
      exp_state(1'b1, 32'h90, 32'd6, 32'd4);
      step();

      // Stall: enE=0 for three cycles then one advancing cycle
      PCF = 32'h200;
      for (int i = 0; i < 3; i++) begin
         br(1'b0, 1'b1, 1'b1, 32'h200, 32'h300, 1'b0);
         expv(ID_MP, 32'd1);
         exp_state(1'b0, 32'd0, 32'd6, 32'd4);
         step();
      end
      br(1'b1, 1'b1, 1'b1, 32'h200, 32'h300, 1'b0);
      step();
      idle();
      exp_state(1'b1, 32'h300, 32'd7, 32'd5);
      step();

      // Alias 0x500 onto the 0x100 slot
      br(1'b1, 1'b1, 1'b1, 32'h500, 32'h40, 1'b0);
      step();
      idle();
      PCF = 32'h100;
      exp_state(1'b0, 32'd0, 32'd8, 32'd6);
      step();
      PCF = 32'h500;
      expv(ID_PF, 32'd1);
      expv(ID_PPC, 32'h40);
      step();

      // Not-taken miss at the same index leaves the table alone
      br(1'b1, 1'b1, 1'b0, 32'h600, 32'h0, 1'b0);
      step();
      idle();
      exp_state(1'b1, 32'h40, 32'd9, 32'd6);
      step();

      // Fall-through wraps at the top of the address space; no update when stalled
      br(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1);
      expv(ID_RPC, 32'h0);
      expv(ID_MP, 32'd1);
      step();

      // Reset concurrent with a taken update discards the update
      rst = 1'b1;
      br(1'b1, 1'b1, 1'b1, 32'h700, 32'h44, 1'b0);
      step();
      rst = 1'b0;
      idle();
      PCF = 32'h700;
      exp_state(1'b0, 32'd0, 32'd0, 32'd0);
      step();
      PCF = 32'h500;
      expv(ID_PF, 32'd0);
      expv(ID_PPC, 32'd0);
      step();

      step();
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard time bound so the run always terminates.
   initial begin
      #100000;
      $display("FAIL timeout: got no completion expected completion by 100000");
      $fatal(1, "timeout");
   end

endmodule
